// File: rtl/systolic_mm_core.sv
// Output-stationary N x M systolic matmul (C = A x B) with input skew, run FSM and row-major drain; SYSTOLIC_SAT_EN selects saturating accumulation.
// Latency: start to first c_valid = 2 + k_len + (N+M-1) cycles when no beat stalls.
// Backpressure: feed accepts only when a_valid & b_valid (bubbles keep alignment); results hold while c_ready is low.
module systolic_mm_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int N          = 3,
  parameter int M          = 3,
  parameter int K_WIDTH    = 8,
  localparam int RW        = (N > 1) ? $clog2(N) : 1,
  localparam int CW        = (M > 1) ? $clog2(M) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [K_WIDTH-1:0]      k_len,
  output logic                    busy,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [N*DATA_WIDTH-1:0] a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [M*DATA_WIDTH-1:0] b_data,
  output logic                    c_valid,
  input  logic                    c_ready,
  output logic [ACC_WIDTH-1:0]    c_data,
  output logic [RW-1:0]           c_row,
  output logic [CW-1:0]           c_col,
  output logic                    c_last,
  output logic                    done
);
  localparam int DCW = $clog2(N + M);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_OUTPUT, S_DONE} state_t;

  state_t             state, state_n;
  logic [K_WIDTH-1:0] k_q, beat_cnt;
  logic [DCW-1:0]     drain_cnt;
  logic [RW-1:0]      row_q;
  logic [CW-1:0]      col_q;
  logic               fire, acc_en, clr, at_last, c_hs;

  logic signed [DATA_WIDTH-1:0] a_edge [N];
  logic signed [DATA_WIDTH-1:0] b_edge [M];
  logic signed [DATA_WIDTH-1:0] a_pipe [N][M];
  logic signed [DATA_WIDTH-1:0] b_pipe [N][M];
  logic signed [ACC_WIDTH-1:0]  acc_flat [N][M];

  assign fire    = (state == S_FEED) && a_valid && b_valid;
  assign acc_en  = (state == S_FEED) || (state == S_DRAIN);
  assign clr     = (state == S_CLEAR);
  assign at_last = (row_q == RW'(N - 1)) && (col_q == CW'(M - 1));
  assign c_hs    = (state == S_OUTPUT) && c_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = (state != S_IDLE);
    a_ready = (state == S_FEED);
    b_ready = (state == S_FEED);
    c_valid = (state == S_OUTPUT);
    c_last  = (state == S_OUTPUT) && at_last;
    done    = (state == S_DONE);
    case (state)
      S_IDLE:   if (start) state_n = S_CLEAR;
      S_CLEAR:  state_n = (k_q == '0) ? S_DRAIN : S_FEED;
      S_FEED:   if (fire && (beat_cnt == k_q - K_WIDTH'(1))) state_n = S_DRAIN;
      S_DRAIN:  if (drain_cnt == DCW'(N + M - 2)) state_n = S_OUTPUT;
      S_OUTPUT: if (c_hs && at_last) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q       <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      if (state == S_IDLE && start) k_q <= k_len;
      if (clr)       beat_cnt <= '0;
      else if (fire) beat_cnt <= beat_cnt + K_WIDTH'(1);
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DCW'(1) : '0;
      if (c_hs) begin
        if (at_last) begin
          row_q <= '0;
          col_q <= '0;
        end else if (col_q == CW'(M - 1)) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  assign c_data = acc_flat[row_q][col_q];
  assign c_row  = row_q;
  assign c_col  = col_q;

  // Row i sees i skew stages; non-accepted cycles inject zero bubbles.
  for (genvar gi = 0; gi < N; gi++) begin : g_askew
    logic signed [DATA_WIDTH-1:0] a_in;
    assign a_in = fire ? a_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (gi == 0) begin : g_direct
      assign a_edge[gi] = a_in;
    end else begin : g_dly
      logic signed [DATA_WIDTH-1:0] sk [gi];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < gi; s++) sk[s] <= '0;
        end else begin
          sk[0] <= a_in;
          for (int s = 1; s < gi; s++) sk[s] <= sk[s-1];
        end
      end
      assign a_edge[gi] = sk[gi-1];
    end
  end

  for (genvar gj = 0; gj < M; gj++) begin : g_bskew
    logic signed [DATA_WIDTH-1:0] b_in;
    assign b_in = fire ? b_data[gj*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (gj == 0) begin : g_direct
      assign b_edge[gj] = b_in;
    end else begin : g_dly
      logic signed [DATA_WIDTH-1:0] sk [gj];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < gj; s++) sk[s] <= '0;
        end else begin
          sk[0] <= b_in;
          for (int s = 1; s < gj; s++) sk[s] <= sk[s-1];
        end
      end
      assign b_edge[gj] = sk[gj-1];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < M; gj++) begin : g_pe
      logic signed [DATA_WIDTH-1:0] a_l, b_t, a_reg, b_reg;
      logic signed [ACC_WIDTH-1:0]  acc_q, acc_nx;

      if (gj == 0) begin : g_al0
        assign a_l = a_edge[gi];
      end else begin : g_aln
        assign a_l = a_pipe[gi][gj-1];
      end
      if (gi == 0) begin : g_bt0
        assign b_t = b_edge[gj];
      end else begin : g_btn
        assign b_t = b_pipe[gi-1][gj];
      end

`ifdef SYSTOLIC_SAT_EN
      localparam int SW = ((2 * DATA_WIDTH > ACC_WIDTH) ? 2 * DATA_WIDTH : ACC_WIDTH) + 1;
      localparam logic signed [SW-1:0] SAT_MAX = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
      localparam logic signed [SW-1:0] SAT_MIN = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
      logic signed [SW-1:0] sum;
      assign sum = SW'(acc_q) + SW'((2*DATA_WIDTH)'(a_l) * (2*DATA_WIDTH)'(b_t));
      always_comb begin
        acc_nx = sum[ACC_WIDTH-1:0];
        if (sum > SAT_MAX)      acc_nx = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else if (sum < SAT_MIN) acc_nx = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end
`else
      // Wrapping modulo 2^ACC_WIDTH only needs the low product bits.
      assign acc_nx = acc_q + ACC_WIDTH'((2*DATA_WIDTH)'(a_l) * (2*DATA_WIDTH)'(b_t));
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
          acc_q <= '0;
        end else begin
          a_reg <= a_l;
          b_reg <= b_t;
          if (clr)         acc_q <= '0;
          else if (acc_en) acc_q <= acc_nx;
        end
      end

      assign a_pipe[gi][gj]   = a_reg;
      assign b_pipe[gi][gj]   = b_reg;
      assign acc_flat[gi][gj] = acc_q;
    end
  end
endmodule

// File: tb/tb_systolic_mm_core.sv
// Directed + randomized bench for systolic_mm_core against a plain matrix-product reference.
// Covers latency, stalls, result backpressure, k_len=0, mid-job reset and accumulator overflow.
module tb_systolic_mm_core;
  localparam int DW = 32, AW = 32, N = 3, M = 3, KW = 8, KMAX = 16;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            a_valid, a_ready, b_valid, b_ready;
  logic [N*DW-1:0] a_data;
  logic [M*DW-1:0] b_data;
  logic            c_valid, c_ready, c_last, done;
  logic [AW-1:0]   c_data;
  logic [1:0]      c_row, c_col;

  systolic_mm_core #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .N(N), .M(M), .K_WIDTH(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .c_row(c_row), .c_col(c_col), .c_last(c_last), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic signed [31:0] am [N][KMAX];
  logic signed [31:0] bm [KMAX][M];
  logic [31:0]        exp_c [N][M];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], wrapped or clamped after every step.
  task automatic compute_ref(input int k);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++) begin
        longint acc = 0;
        for (int kk = 0; kk < k; kk++) begin
          acc = acc + longint'(am[i][kk]) * longint'(bm[kk][j]);
`ifdef SYSTOLIC_SAT_EN
          if (acc > 64'sd2147483647)  acc = 64'sd2147483647;
          if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`else
          acc = longint'(signed'(acc[31:0]));
`endif
        end
        exp_c[i][j] = acc[31:0];
      end
  endtask

  task automatic clear_mats();
    for (int i = 0; i < N; i++) for (int kk = 0; kk < KMAX; kk++) am[i][kk] = 0;
    for (int kk = 0; kk < KMAX; kk++) for (int j = 0; j < M; j++) bm[kk][j] = 0;
  endtask

  task automatic set_identity();
    clear_mats();
    for (int i = 0; i < N; i++) am[i][i] = 1;
    for (int kk = 0; kk < 3; kk++) for (int j = 0; j < M; j++) bm[kk][j] = kk * 3 + j + 1;
  endtask

  task automatic drive_beat(input int beat, input bit av, input bit bv);
    a_data = {$urandom, $urandom, $urandom};
    b_data = {$urandom, $urandom, $urandom};
    if (av) for (int i = 0; i < N; i++) a_data[i*DW +: DW] = am[i][beat];
    if (bv) for (int j = 0; j < M; j++) b_data[j*DW +: DW] = bm[beat][j];
    a_valid = av;
    b_valid = bv;
  endtask

  // mode: 0 valids held, 1 a alternate + b late, 2 random. bp: 0 ready, 1 hold at (1,1), 2 random.
  task automatic run_job(input string tag, input int k, input int mode, input int bp, input bit chk_lat);
    int beat = 0, idx = 0, hold = 0, first_cv = -1, last_hs = -1, done_cyc = -1, ready_cycles = 0;
    bit finished = 0;
    bit av, bv, cr;
    compute_ref(k);
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      if (a_ready) ready_cycles++;
      if (c_valid) begin
        if (first_cv < 0) first_cv = cyc;
        if (idx < N * M) begin
          chk({tag, "_data"}, c_data, exp_c[idx / M][idx % M]);
          chk({tag, "_row"}, c_row, idx / M);
          chk({tag, "_col"}, c_col, idx % M);
          chk({tag, "_last"}, c_last, idx == N * M - 1);
        end else begin
          chk({tag, "_extra_valid"}, c_valid, 0);
        end
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk({tag, "_busy_after_done"}, busy, 0);
        chk({tag, "_done_one_cycle"}, done, 0);
        finished = 1;
      end
      start = (cyc == 0) || (cyc == 3);
      k_len = (cyc == 3) ? KW'($urandom) : KW'(k);
      case (mode)
        0:       begin av = beat < k; bv = beat < k; end
        1:       begin av = (beat < k) && (cyc % 2 == 0); bv = (beat < k) && (cyc >= 6); end
        default: begin av = (beat < k) && $urandom_range(0, 2) != 0; bv = (beat < k) && $urandom_range(0, 2) != 0; end
      endcase
      drive_beat(beat, av, bv);
      if (a_ready && av && bv) beat++;
      if (bp == 1 && idx == 4 && hold > 0 && hold < 6) chk({tag, "_hold_valid"}, c_valid, 1);
      case (bp)
        0:       cr = 1;
        1:       cr = !(idx == 4 && c_valid && hold < 5);
        default: cr = $urandom_range(0, 1) == 1;
      endcase
      if (bp == 1 && !cr) hold++;
      c_ready = cr;
      if (c_valid && cr) begin
        if (idx == N * M - 1) last_hs = cyc;
        idx++;
      end
    end
    start = 0; a_valid = 0; b_valid = 0; c_ready = 1;
    chk({tag, "_finished"}, finished, 1);
    chk({tag, "_count"}, idx, N * M);
    chk({tag, "_beats"}, beat, k);
    chk({tag, "_done_after_last"}, done_cyc, last_hs + 1);
    if (k == 0) chk({tag, "_no_ready"}, ready_cycles, 0);
    if (bp == 1) chk({tag, "_hold_cycles"}, hold, 5);
    if (chk_lat) chk({tag, "_latency"}, first_cv, k + N + M + 1);
  endtask

  initial begin
    int n;
    rst = 1; start = 0; k_len = '0; a_valid = 0; b_valid = 0; c_ready = 1;
    a_data = '0; b_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_c_valid", c_valid, 0);
    chk("rst_c_last", c_last, 0);
    chk("rst_done", done, 0);
    chk("rst_c_data", c_data, 0);
    chk("rst_c_row", c_row, 0);
    chk("rst_c_col", c_col, 0);
    rst = 0;

    set_identity();
    run_job("ident", 3, 0, 0, 1);
    run_job("stall", 3, 1, 0, 0);
    run_job("bp", 3, 0, 1, 1);
    run_job("k0", 0, 0, 0, 1);

    // Reset after exactly one accepted beat of a 3-beat job.
    set_identity();
    @(negedge clk);
    start = 1; k_len = 3;
    drive_beat(0, 1, 1);
    n = 0;
    @(negedge clk);
    start = 0;
    while (!a_ready && n < 10) begin @(negedge clk); n++; end
    chk("midrst_reached_feed", a_ready, 1);
    @(negedge clk);
    rst = 1; a_valid = 0; b_valid = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_a_ready", a_ready, 0);
    chk("midrst_b_ready", b_ready, 0);
    chk("midrst_c_valid", c_valid, 0);
    chk("midrst_c_data", c_data, 0);
    chk("midrst_c_rowcol", {c_row, c_col}, 0);
    chk("midrst_c_last", c_last, 0);
    chk("midrst_done", done, 0);
    rst = 0;
    run_job("post_rst", 3, 0, 0, 1);

    clear_mats();
    for (int kk = 0; kk < 2; kk++) begin am[0][kk] = 32'h0001_0000; bm[kk][0] = 32'h0001_0000; end
    run_job("ovf", 2, 0, 0, 1);

    for (int r = 0; r < 6; r++) begin
      int k;
      k = $urandom_range(1, 8);
      for (int i = 0; i < N; i++) for (int kk = 0; kk < KMAX; kk++)
        am[i][kk] = (r % 2 == 0) ? $urandom : $signed($urandom_range(0, 200)) - 100;
      for (int kk = 0; kk < KMAX; kk++) for (int j = 0; j < M; j++)
        bm[kk][j] = (r % 2 == 0) ? $urandom : $signed($urandom_range(0, 200)) - 100;
      run_job("rand", k, 2, 2, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_mm_core.md
Name: systolic_mm_core

Overview:
Parametrised N x M output-stationary systolic matrix-multiply core with built-in input skew, run control and result drain.
- Computes C = A x B for an inner dimension of k_len, 0..2^K_WIDTH-1.
- A columns and B rows arrive as unskewed parallel beats over a joint valid/ready handshake.
- Results stream out row-major over valid/ready.
- Replaces the fixed 3x3 array with its external enable sequencing.

Parameters:
DATA_WIDTH, 32, operand width; operands are signed two's complement.
ACC_WIDTH, 32, accumulator and result width.
N, 3, PE rows (rows of A and C).
M, 3, PE columns (columns of B and C).
K_WIDTH, 8, width of k_len.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
start  in  1  begin a job; sampled only in IDLE.
k_len  in  K_WIDTH  inner dimension; sampled with start.
busy  out  1  high in every state except IDLE.
a_valid  in  1  A beat valid.
a_ready  out  1  A beat ready.
a_data  in  N*DATA_WIDTH  A[i][k] in slice i.
b_valid  in  1  B beat valid.
b_ready  out  1  B beat ready.
b_data  in  M*DATA_WIDTH  B[k][j] in slice j.
c_valid  out  1  result valid.
c_ready  in  1  result ready.
c_data  out  ACC_WIDTH  C[row][col].
c_row  out  clog2(N) (min 1)  row index of c_data.
c_col  out  clog2(M) (min 1)  column index of c_data.
c_last  out  1  marks the final result of a job.
done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: rst high at any edge, including mid-job, forces the following. Reset wins over all other events.
  - State IDLE; all accumulators, skew and pipe registers cleared to 0.
  - busy, a_ready, b_ready, c_valid, c_last and done all 0.
  - c_data, c_row and c_col all 0.
- FSM states: IDLE, CLEAR, FEED, DRAIN, OUTPUT, DONE.
- IDLE:
  - start=1 latches k_len and moves to CLEAR.
  - start in any other state is ignored.
- CLEAR: one cycle; zeroes all N*M accumulators; goes to FEED, or to DRAIN if k_len==0.
- FEED:
  - a_ready = b_ready = 1.
  - A beat is accepted only on an edge with a_valid & b_valid, which consumes both streams.
  - One-sided valid consumes nothing.
  - Beat counter increments per accepted beat; after the k_len-th beat, go to DRAIN.
  - Cycles without an accepted beat inject 0 into every row and column (bubble). Alignment is preserved, so stalls never change results.
- Skew and array:
  - Row i input passes i delay registers; column j input passes j delay registers.
  - Each PE registers A rightward and B downward.
  - PE(i,j) accumulates the beat accepted at edge t on edge t+i+j.
  - Accumulation is enabled in FEED and DRAIN only.
- DRAIN: exactly N+M-1 cycles of zero injection, then OUTPUT.
- OUTPUT:
  - Presents C in row-major order (0,0), (0,1) … (N-1,M-1).
  - The index advances only on c_valid & c_ready.
  - c_data, c_row and c_col are held stable while c_valid=1 and c_ready=0.
  - c_last=1 with element (N-1,M-1).
  - On that element's handshake, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic:
  - Product is a full 2*DATA_WIDTH signed value.
  - Sum is formed without loss, then wrapped modulo 2^ACC_WIDTH.
- Minimum job latency: start to first c_valid = 1 + 1 + k_len + (N+M-1) cycles with no stalls.

Optional Feature:
SYSTOLIC_SAT_EN
- Defined: each accumulate step saturates to the signed ACC_WIDTH range, max 2^(ACC_WIDTH-1)-1 and min -2^(ACC_WIDTH-1). Saturation is sticky per step.
- Undefined: two's-complement wrap as in Behaviour.
- Ports and timing are identical in both builds.

Test Plan:
- Identity product: A=I3, B rows {1,2,3},{4,5,6},{7,8,9}, k_len=3, all valids held, c_ready=1 → c_data 1..9 in row-major order with matching c_row/c_col; c_last on 9; done one cycle after; busy falls the next cycle.
- Stalls: same job with a_valid low on alternate cycles and b_valid delayed 4 cycles → identical 9 results; no beat is consumed with only one valid high.
- Backpressure: c_ready low for 5 cycles at element (1,1) → c_valid stays 1 and c_data stays 5 for those cycles; sequence resumes with 6.
- k_len=0 → no a_ready/b_ready handshakes; 9 results all 0; c_last on the 9th; done pulses.
- Reset mid-FEED after 1 of 3 beats → next cycle busy=0 and all outputs 0; a fresh identity job then returns 1..9.
- Overflow: A[0][k]=B[k][0]=0x00010000, k_len=2 → C[0][0]=0x00000000 without SYSTOLIC_SAT_EN and 0x7FFFFFFF with it.
